// File: rtl/zbt_sram_ctrl.sv
// ZBT (zero-bus-turnaround) synchronous SRAM controller: a lock-gated INIT/RUN
// state machine in front of a 3-stage request pipeline that matches the RAM's
// two-cycle data latency, so reads and writes can be mixed at full rate.
module zbt_sram_ctrl #(
  parameter int INIT_CYCLES = 16,
  parameter int AW          = 19,
  parameter int DW          = 36
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          locked,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we_b,
  output logic          ram_cen_b,
  output logic          ram_oe_b,
  output logic [DW-1:0] ram_data_out,
  output logic          ram_data_oe,
  input  logic [DW-1:0] ram_data_in
);

  typedef enum logic {INIT, RUN} state_t;

  localparam int CW = $clog2(INIT_CYCLES + 1);

  state_t          state;
  logic [CW-1:0]   init_cnt;
  logic            accept;

  // Stage 1 is the address cycle, stage 2 the RAM's internal cycle and
  // stage 3 the cycle in which data sits on the bus.
  logic            s1_valid, s1_we;
  logic            s2_valid, s2_we;
  logic            s3_valid, s3_we;
  logic [DW-1:0]   s1_wdata, s2_wdata;

  assign req_ready = (state == RUN) && locked;
  assign accept    = req_valid && req_ready;
  assign busy      = s1_valid || s2_valid || s3_valid;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse pipeline stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too because their reset
      // values are visible on the RAM pins and on rd_data.
      state        <= INIT;
      init_cnt     <= '0;
      s1_valid     <= 1'b0;
      s1_we        <= 1'b0;
      s1_wdata     <= '0;
      s2_valid     <= 1'b0;
      s2_we        <= 1'b0;
      s2_wdata     <= '0;
      s3_valid     <= 1'b0;
      s3_we        <= 1'b0;
      ram_addr     <= '0;
      ram_we_b     <= 1'b1;
      ram_cen_b    <= 1'b1;
      ram_oe_b     <= 1'b1;
      ram_data_out <= '0;
      ram_data_oe  <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      // ram_cen_b follows the next state so it tracks INIT/RUN cycle-exactly.
      case (state)
        INIT: begin
          if (!locked) begin
            init_cnt <= '0;
          end else if (init_cnt == CW'(INIT_CYCLES - 1)) begin
            state     <= RUN;
            init_cnt  <= '0;
            ram_cen_b <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked) begin
            state     <= INIT;
            init_cnt  <= '0;
            ram_cen_b <= 1'b1;
          end
        end
        default: begin
          state     <= INIT;
          init_cnt  <= '0;
          ram_cen_b <= 1'b1;
        end
      endcase

      // Address cycle; the address is held between accepted requests.
      s1_valid <= accept;
      s1_we    <= req_we;
      s1_wdata <= req_wdata;
      if (accept) ram_addr <= req_addr;
      ram_we_b <= !(accept && req_we);

      s2_valid <= s1_valid;
      s2_we    <= s1_we;
      s2_wdata <= s1_wdata;

      // Bus cycle: drive write data or open the RAM's output for a read.
      s3_valid    <= s2_valid;
      s3_we       <= s2_we;
      ram_data_oe <= s2_valid && s2_we;
      ram_oe_b    <= !(s2_valid && !s2_we);
      if (s2_valid && s2_we) ram_data_out <= s2_wdata;

      // Capture read data at the end of the bus cycle; rd_data holds otherwise.
      rd_valid <= s3_valid && !s3_we;
      if (s3_valid && !s3_we) rd_data <= ram_data_in;
    end
  end

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
// Directed bench for zbt_sram_ctrl with a small ZBT RAM model (two-cycle
// data latency) and a read scoreboard fed from a shadow copy of the RAM.
module tb_zbt_sram_ctrl;

  localparam int AW = 19;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic          locked;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we_b;
  logic          ram_cen_b;
  logic          ram_oe_b;
  logic [DW-1:0] ram_data_out;
  logic          ram_data_oe;
  logic [DW-1:0] ram_data_in;

  int tests  = 0;
  int fails  = 0;
  int strobes = 0;

  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];
  logic [DW-1:0] exp_q  [$];
  logic [AW-1:0] p1_addr, p2_addr;
  logic          p1_we,   p2_we;

  always #5 clk = ~clk;

  zbt_sram_ctrl #(.INIT_CYCLES(16), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .locked       (locked),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_we_b     (ram_we_b),
    .ram_cen_b    (ram_cen_b),
    .ram_oe_b     (ram_oe_b),
    .ram_data_out (ram_data_out),
    .ram_data_oe  (ram_data_oe),
    .ram_data_in  (ram_data_in)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // RAM model: address/we seen in cycle N+1, data on the bus in cycle N+3.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    p1_addr = '0; p2_addr = '0; p1_we = 1'b1; p2_we = 1'b1;
  end

  always @(posedge clk) begin
    p1_addr <= ram_addr;
    p1_we   <= ram_we_b;
    p2_addr <= p1_addr;
    p2_we   <= p1_we;
    if (p2_we == 1'b0) mem[p2_addr[7:0]] <= ram_data_out;
  end

  assign ram_data_in = mem[p2_addr[7:0]];

  // Read scoreboard: every rd_valid strobe must match the oldest accepted read.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) check("rd_unexpected", {{(DW-1){1'b0}}, rd_valid}, '0);
      else check("rd_order", rd_data, exp_q.pop_front());
    end
  end

  // One cycle of stimulus; acceptance is judged on the settled inputs.
  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = v; req_we = w; req_addr = a; req_wdata = d;
    #1;
    if (v && req_ready) begin
      if (w) shadow[a[7:0]] = d;
      else   exp_q.push_back(shadow[a[7:0]]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || busy || rd_valid) && k < 20) begin
      idle(1);
      k++;
    end
    check(tag, {{(DW-1){1'b0}}, (k < 20)}, 1);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; locked = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset values.
    apply_reset();
    check("rst_ready",   req_ready,    0);
    check("rst_rdvalid", rd_valid,     0);
    check("rst_busy",    busy,         0);
    check("rst_we_b",    ram_we_b,     1);
    check("rst_cen_b",   ram_cen_b,    1);
    check("rst_oe_b",    ram_oe_b,     1);
    check("rst_data_oe", ram_data_oe,  0);
    check("rst_addr",    ram_addr,     0);
    check("rst_dout",    ram_data_out, 0);
    check("rst_rddata",  rd_data,      0);

    // Lock held from reset release: ready after exactly 16 edges.
    reset = 1'b0; locked = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("init_ready_%0d", k), req_ready, (k == 16) ? 1 : 0);
    end
    check("run_cen_b", ram_cen_b, 0);

    // Lock drops for the 10th edge: count restarts, ready after edge 26.
    apply_reset();
    reset = 1'b0; locked = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      locked = (k == 9) ? 1'b0 : 1'b1;
      if (k >= 15) check($sformatf("pulse_ready_%0d", k), req_ready, (k == 26) ? 1 : 0);
    end

    // Single write: address in N+1, data on the bus only in N+3.
    drive(1'b1, 1'b1, 19'h00005, 36'h123456789);
    idle(1);
    check("wr_addr",   ram_addr,    19'h00005);
    check("wr_we_b",   ram_we_b,    0);
    check("wr_oe_n2",  ram_data_oe, 0);
    idle(1);
    check("wr_oe_n2b", ram_data_oe, 0);
    idle(1);
    check("wr_oe_n3",  ram_data_oe, 1);
    check("wr_dout",   ram_data_out, 36'h123456789);
    check("wr_rdoe_b", ram_oe_b,    1);
    idle(1);
    check("wr_oe_n4",  ram_data_oe, 0);
    check("wr_we_idle", ram_we_b,   1);
    check("wr_addr_hold", ram_addr, 19'h00005);

    // Single read: ram_oe_b low in N+3, data returned in N+4 and then held.
    drive(1'b1, 1'b0, 19'h00005, '0);
    idle(1);
    check("rd_we_b",   ram_we_b, 1);
    check("rd_busy",   busy,     1);
    idle(1);
    check("rd_oe_n2",  ram_oe_b, 1);
    idle(1);
    check("rd_oe_n3",  ram_oe_b, 0);
    check("rd_doe_n3", ram_data_oe, 0);
    idle(1);
    check("rd_valid_n4", rd_valid, 1);
    check("rd_data_n4",  rd_data,  36'h123456789);
    check("rd_oe_n4",    ram_oe_b, 1);
    idle(1);
    check("rd_valid_n5", rd_valid, 0);
    check("rd_hold",     rd_data,  36'h123456789);
    check("rd_idle_busy", busy,    0);

    // Alternating W/R on addresses 0..7 at full rate.
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, AW'(i), 36'hA_5000_0000 + DW'(i * 36'h1_0101));
      check($sformatf("alt_ready_w%0d", i), req_ready, 1);
      drive(1'b1, 1'b0, AW'(i), '0);
      check($sformatf("alt_ready_r%0d", i), req_ready, 1);
    end
    wait_drain("alt_drain");
    check("alt_strobes", strobes, 8);

    // Lock drops with a write and a read in flight.
    drive(1'b1, 1'b1, 19'h00009, 36'hF_EDCB_A987);
    drive(1'b1, 1'b0, 19'h00009, '0);
    @(negedge clk);
    req_valid = 1'b0; locked = 1'b0;
    #1;
    check("drop_ready", req_ready, 0);
    @(negedge clk);
    check("drop_cen_b", ram_cen_b, 1);
    check("drop_busy",  busy,      1);
    strobes = 0;
    wait_drain("drop_drain");
    check("drop_strobes", strobes, 1);

    // Relock, then reset one cycle after a read is accepted.
    locked = 1'b1;
    idle(16);
    check("relock_ready", req_ready, 1);
    drive(1'b1, 1'b0, 19'h00005, '0);
    apply_reset();
    check("mid_rdvalid", rd_valid,    0);
    check("mid_busy",    busy,        0);
    check("mid_cen_b",   ram_cen_b,   1);
    check("mid_oe_b",    ram_oe_b,    1);
    check("mid_addr",    ram_addr,    0);
    check("mid_rddata",  rd_data,     0);
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("mid_doe_%0d", k), ram_data_oe, 0);
    end
    check("mid_strobes", strobes, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/zbt_sram_ctrl.md
ZBT_SRAM_CTRL -- requirements
Module: zbt_sram_ctrl

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 16, cycles to wait after locked rises before accepting requests.
REQ-002 SHALL have parameter AW, default 19, RAM address width.
REQ-003 SHALL have parameter DW, default 36, RAM data width.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  fpga clock (deskewed, same edge as RAM clock).
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 locked  input  1  clock-generator lock indication.
REQ-008 req_valid  input  1  client request present.
REQ-009 req_ready  output  1  controller accepts request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  AW  word address.
REQ-012 req_wdata  input  DW  write data.
REQ-013 rd_valid  output  1  one-cycle strobe, rd_data valid.
REQ-014 rd_data  output  DW  read data.
REQ-015 busy  output  1  any operation in flight.
REQ-016 ram_addr  output  AW  RAM address pins.
REQ-017 ram_we_b  output  1  RAM write enable, active-low.
REQ-018 ram_cen_b  output  1  RAM clock enable, active-low.
REQ-019 ram_oe_b  output  1  RAM output enable, active-low.
REQ-020 ram_data_out  output  DW  data driven to RAM.
REQ-021 ram_data_oe  output  1  1 = FPGA drives data bus (tristate done at top level).
REQ-022 ram_data_in  input  DW  data bus sampled from RAM.

Function
REQ-023 SHALL implement states INIT and RUN; INIT counts consecutive locked=1 cycles, goes to RUN when count reaches INIT_CYCLES; any locked=0 cycle clears count.
REQ-024 SHALL go RUN -> INIT in the cycle after locked=0 is sampled; in-flight operations SHALL still complete.
REQ-025 req_ready SHALL equal (state==RUN && locked); acceptance = req_valid && req_ready; one request per cycle, no bubbles.
REQ-026 All ram_* outputs SHALL be registered; an op accepted at edge N appears on ram_addr/ram_we_b in cycle N+1.
REQ-027 Cycles without acceptance SHALL drive ram_we_b=1, ram_addr held; ram_cen_b SHALL be 0 in RUN, 1 in INIT.
REQ-028 Write: req_wdata SHALL be carried in a 2-stage pipeline and driven on ram_data_out with ram_data_oe=1 exactly in cycle N+3; ram_data_oe=0 otherwise.
REQ-029 Read: ram_data_in SHALL be captured at the end of cycle N+3; rd_valid=1 and rd_data valid in cycle N+4 (read latency 4 from acceptance edge).
REQ-030 Back-to-back mixes (W,R,W,R...) SHALL run at full rate with no turnaround cycle; ordering of rd_valid SHALL match read acceptance order.
REQ-031 ram_oe_b SHALL be 0 only in cycles where a read's data is expected on the bus (N+3), else 1.
REQ-032 busy SHALL be 1 while any of the 3 pipeline stages holds a valid op.
REQ-033 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-034 On reset: state=INIT, counter=0, pipeline valids cleared, req_ready=0, rd_valid=0, busy=0, ram_we_b=1, ram_cen_b=1, ram_oe_b=1, ram_data_oe=0, ram_addr=0, ram_data_out=0, rd_data=0.
REQ-035 Reset mid-operation SHALL discard in-flight ops: no rd_valid and no ram_data_oe after the reset edge.

Verification
REQ-036 locked=1 from reset release -> req_ready rises after exactly 16 cycles; locked pulses low at cycle 10 -> count restarts.
REQ-037 write addr 0x00005 data 0x123456789 at edge N -> ram_addr=5, ram_we_b=0 in N+1; ram_data_out=0x123456789, ram_data_oe=1 in N+3 only.
REQ-038 read addr 0x00005, RAM model returns 0x123456789 -> rd_valid=1, rd_data=0x123456789 in N+4, ram_oe_b=0 in N+3.
REQ-039 alternating W/R on addrs 0..7 for 16 cycles, req_valid held high -> no stall, 8 rd_valid strobes in order with written data.
REQ-040 locked drops with 2 ops in flight -> req_ready=0 next cycle, both ops complete, ram_cen_b=1 once state is INIT.
REQ-041 reset asserted one cycle after a read is accepted -> no rd_valid, all outputs at reset values.
